// File: rtl/risc_alu.sv
// risc_alu: 32-bit execute-stage ALU (add, two's complement, AND, XOR, shifts).
// Result and zero flag are registered, so each result appears one clock after its operands.
module risc_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Input1,
  input  logic [31:0] Input2,
  input  logic        isTwoC,
  input  logic [1:0]  Operation,
  input  logic [2:0]  SetFlag,
  input  logic        LeftOrRight,
  input  logic        isArith,
  output logic [31:0] Result,
  output logic        zero
);

  typedef enum logic [1:0] {
    OP_ARITH = 2'b00,
    OP_AND   = 2'b01,
    OP_XOR   = 2'b10,
    OP_SHIFT = 2'b11
  } op_e;

  op_e         op;
  logic [4:0]  sh;
  logic [31:0] arith_res;
  logic [31:0] shift_res;
  logic [31:0] alu_res;

  logic [31:0] Result_q, Result_d;
  logic        zero_q,   zero_d;

  // SetFlag[2:1] are reserved and deliberately have no effect.
  logic unused_setflag_hi;
  assign unused_setflag_hi = ^SetFlag[2:1];

  assign op = op_e'(Operation);
  assign sh = Input2[4:0];

  // Adder / negator: two's complement ignores Input1 entirely.
  always_comb begin
    arith_res = '0;
    if (isTwoC) begin
      arith_res = ~Input2 + 32'd1;
    end else begin
      arith_res = Input1 + Input2;
    end
  end

  // Barrel shifter: left is always zero fill; right fill selected by isArith.
  always_comb begin
    shift_res = '0;
    if (!LeftOrRight) begin
      shift_res = Input1 << sh;
    end else if (isArith) begin
      shift_res = $unsigned($signed(Input1) >>> sh);
    end else begin
      shift_res = Input1 >> sh;
    end
  end

  // Operation select.
  always_comb begin
    alu_res = '0;
    unique case (op)
      OP_ARITH: alu_res = arith_res;
      OP_AND:   alu_res = Input1 & Input2;
      OP_XOR:   alu_res = Input1 ^ Input2;
      OP_SHIFT: alu_res = shift_res;
      default:  alu_res = '0;
    endcase
  end

  // Next-state: Result always updates, zero only when SetFlag[0] is set.
  always_comb begin
    Result_d = alu_res;
    zero_d   = zero_q;
    if (SetFlag[0]) begin
      zero_d = (alu_res == '0);
    end
  end

  // Output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      Result_q <= Result_d;
      zero_q   <= zero_d;
    end
  end

  assign Result = Result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_risc_alu.sv
// tb_risc_alu: directed vectors with a scoreboard queue and a negedge monitor.
module tb_risc_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] Input1;
  logic [31:0] Input2;
  logic        isTwoC;
  logic [1:0]  Operation;
  logic [2:0]  SetFlag;
  logic        LeftOrRight;
  logic        isArith;
  logic [31:0] Result;
  logic        zero;

  typedef struct {
    logic [31:0] res;
    logic        z;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  risc_alu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Input1      (Input1),
    .Input2      (Input2),
    .isTwoC      (isTwoC),
    .Operation   (Operation),
    .SetFlag     (SetFlag),
    .LeftOrRight (LeftOrRight),
    .isArith     (isArith),
    .Result      (Result),
    .zero        (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one vector for one clock, then post its expected registered outputs.
  task automatic issue(input logic rst, input logic [31:0] a, input logic [31:0] b,
                       input logic tc, input logic [1:0] op, input logic [2:0] sf,
                       input logic lr, input logic ar,
                       input logic [31:0] exp_res, input logic exp_z, input string name);
    exp_t e;
    @(negedge clk);
    rst_n       = rst;
    Input1      = a;
    Input2      = b;
    isTwoC      = tc;
    Operation   = op;
    SetFlag     = sf;
    LeftOrRight = lr;
    isArith     = ar;
    @(posedge clk);
    #1;
    e.res  = exp_res;
    e.z    = exp_z;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are stable at negedge; pop one expectation per cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (Result !== e.res) begin
        failures++;
        $display("FAIL %s.Result actual=%08h required=%08h", e.name, Result, e.res);
      end
      checks++;
      if (zero !== e.z) begin
        failures++;
        $display("FAIL %s.zero actual=%0b required=%0b", e.name, zero, e.z);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cycles;
    rst_n = 1'b0; Input1 = '0; Input2 = '0; isTwoC = 1'b0; Operation = 2'b00;
    SetFlag = 3'b000; LeftOrRight = 1'b0; isArith = 1'b0;

    //      rst   Input1        Input2        tc    op     sf      lr    ar    Result        z
    issue(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 2'b00, 3'b111, 1'b0, 1'b0, 32'h0000_0000, 1'b0, "reset0");
    issue(1'b0, 32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 2'b10, 3'b111, 1'b0, 1'b0, 32'h0000_0000, 1'b0, "reset1");
    issue(1'b1, 32'h2A85_5ECD, 32'h9AA5_5ECD, 1'b0, 2'b00, 3'b111, 1'b0, 1'b0, 32'hC52A_BD9A, 1'b0, "add");
    issue(1'b1, 32'h2A85_5ECD, 32'h2A85_5ECD, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 32'hD57A_A133, 1'b0, "twoc");
    issue(1'b1, 32'h0000_0005, 32'hFFFF_FFFB, 1'b0, 2'b00, 3'b001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, "add_zero");
    issue(1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0, 32'hF000_F000, 1'b1, "and_hold");
    issue(1'b1, 32'h8000_0000, 32'h0000_0024, 1'b0, 2'b11, 3'b000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, "shl4");
    issue(1'b1, 32'h8000_0000, 32'h0000_0024, 1'b0, 2'b11, 3'b001, 1'b1, 1'b1, 32'hF800_0000, 1'b0, "sra4");
    issue(1'b1, 32'h8000_0000, 32'h0000_0024, 1'b0, 2'b11, 3'b000, 1'b1, 1'b0, 32'h0800_0000, 1'b0, "srl4");
    issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 2'b00, 3'b001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, "twoc_zero");
    issue(1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 2'b00, 3'b001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, "twoc_min");
    issue(1'b1, 32'h1234_5678, 32'hFFFF_FFE0, 1'b0, 2'b11, 3'b001, 1'b1, 1'b1, 32'h1234_5678, 1'b0, "sh0");
    issue(1'b1, 32'h4000_0000, 32'h0000_001F, 1'b0, 2'b11, 3'b001, 1'b1, 1'b1, 32'h0000_0000, 1'b1, "sra31_pos");
    issue(1'b1, 32'h0000_0001, 32'h0000_001F, 1'b1, 2'b11, 3'b110, 1'b0, 1'b1, 32'h8000_0000, 1'b1, "shl31_rsvd");
    issue(1'b1, 32'h0F0F_0F0F, 32'h00FF_00FF, 1'b1, 2'b01, 3'b001, 1'b1, 1'b1, 32'h000F_000F, 1'b0, "and_ign");
    issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 2'b00, 3'b001, 1'b0, 1'b0, 32'h0000_0001, 1'b0, "add_wrap");
    issue(1'b1, 32'hAAAA_5555, 32'hFFFF_0000, 1'b0, 2'b10, 3'b001, 1'b0, 1'b0, 32'h5555_5555, 1'b0, "xor");
    issue(1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1, 2'b10, 3'b001, 1'b1, 1'b0, 32'h0000_0000, 1'b1, "xor_zero");
    issue(1'b0, 32'h2A85_5ECD, 32'h9AA5_5ECD, 1'b0, 2'b00, 3'b111, 1'b0, 1'b0, 32'h0000_0000, 1'b0, "reset_mid");
    issue(1'b1, 32'hFFFF_FFFF, 32'h0F00_0000, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0, 32'h0F00_0000, 1'b0, "after_rst");

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 5) begin
      @(negedge clk);
      #1;
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
